// File: rtl/note_metadata_scheduler.sv
// note_metadata_scheduler
// Shares the single read port of the song note-time memory among the per-note
// matchers. On start it preloads entry 0 of every note, then serves request
// edges round-robin, one outstanding read at a time.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             single-cycle pulse: clear state and preload all notes
//   metadata_request  per-note request, rising edge = fetch next entry
//   metadata_link     per-note target time, slice i = [i*TIME_W +: TIME_W]
//   link_valid        slice i holds a fetched value
//   mem_rd_en         read strobe, one cycle per fetch
//   mem_addr          {note_index, entry_index}
//   mem_rdata         read data, valid RD_LAT cycles after mem_rd_en
//   init_done         high from preload completion until next start/reset
//   busy              fetch in flight or preload active
module note_metadata_scheduler #(
  parameter int unsigned NOTES  = 37,
  parameter int unsigned TIME_W = 16,
  parameter int unsigned IDX_W  = 8,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned NOTE_W = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [NOTES-1:0]          metadata_request,
  output logic [NOTES*TIME_W-1:0]   metadata_link,
  output logic [NOTES-1:0]          link_valid,
  output logic                      mem_rd_en,
  output logic [NOTE_W+IDX_W-1:0]   mem_addr,
  input  logic [TIME_W-1:0]         mem_rdata,
  output logic                      init_done,
  output logic                      busy
);

  localparam int unsigned CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT_ISSUE,
    S_INIT_WAIT,
    S_RUN,
    S_WAIT
  } state_t;

  state_t              state, state_next;
  logic [NOTES-1:0]    req_q;
  logic [NOTES-1:0]    pending;
  logic [NOTES-1:0]    exhausted;
  logic [NOTES-1:0]    pend_set;
  logic [NOTES-1:0]    pend_clr;
  logic [IDX_W-1:0]    ptr [NOTES];
  logic [NOTE_W-1:0]   last_grant;
  logic [NOTE_W-1:0]   grant;
  logic [NOTE_W-1:0]   init_idx;
  logic [NOTE_W-1:0]   rr_pick;
  logic [NOTE_W-1:0]   rr_cand;
  logic                rr_found;
  logic [CNT_W-1:0]    lat_cnt;
  logic                lat_last;
  logic                cap_en;
  logic [NOTE_W-1:0]   cap_idx;

  assign lat_last = (lat_cnt == CNT_W'(RD_LAT - 1));

  // Round-robin search starting just after the previous grant.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = '0;
    rr_cand  = (last_grant == NOTE_W'(NOTES - 1)) ? '0 : last_grant + 1'b1;
    for (int unsigned k = 0; k < NOTES; k++) begin
      if (!rr_found && pending[rr_cand]) begin
        rr_found = 1'b1;
        rr_pick  = rr_cand;
      end
      rr_cand = (rr_cand == NOTE_W'(NOTES - 1)) ? '0 : rr_cand + 1'b1;
    end
  end

  // Request edges are only accepted once the preload has finished.
  always_comb begin
    pend_set = '0;
    pend_clr = '0;
    if (state == S_RUN || state == S_WAIT)
      pend_set = metadata_request & ~req_q & ~exhausted;
    if (state == S_RUN && rr_found)
      pend_clr[rr_pick] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    mem_rd_en  = 1'b0;
    mem_addr   = '0;
    busy       = 1'b0;
    cap_en     = 1'b0;
    cap_idx    = grant;
    case (state)
      S_IDLE: ;
      S_INIT_ISSUE: begin
        mem_rd_en  = 1'b1;
        mem_addr   = {init_idx, {IDX_W{1'b0}}};
        busy       = 1'b1;
        state_next = S_INIT_WAIT;
      end
      S_INIT_WAIT: begin
        busy = 1'b1;
        if (lat_last) begin
          cap_en     = 1'b1;
          cap_idx    = init_idx;
          state_next = (init_idx == NOTE_W'(NOTES - 1)) ? S_RUN : S_INIT_ISSUE;
        end
      end
      S_RUN: begin
        if (rr_found) begin
          mem_rd_en  = 1'b1;
          mem_addr   = {rr_pick, ptr[rr_pick]};
          busy       = 1'b1;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        busy = 1'b1;
        if (lat_last) begin
          cap_en     = 1'b1;
          state_next = S_RUN;
        end
      end
      default: state_next = S_IDLE;
    endcase
    // start overrides everything; the in-flight read is simply never captured.
    if (start) begin
      state_next = S_INIT_ISSUE;
      cap_en     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q         <= '0;
      pending       <= '0;
      exhausted     <= '0;
      last_grant    <= '0;
      grant         <= '0;
      init_idx      <= '0;
      lat_cnt       <= '0;
      metadata_link <= '0;
      link_valid    <= '0;
      init_done     <= 1'b0;
      for (int unsigned i = 0; i < NOTES; i++) ptr[i] <= '0;
    end else begin
      req_q <= metadata_request;
      if (start) begin
        // metadata_link and last_grant are deliberately held.
        pending    <= '0;
        exhausted  <= '0;
        link_valid <= '0;
        init_done  <= 1'b0;
        init_idx   <= '0;
        lat_cnt    <= '0;
        for (int unsigned i = 0; i < NOTES; i++) ptr[i] <= '0;
      end else begin
        // Set wins over clear so a re-request during its own grant is kept.
        pending <= (pending & ~pend_clr) | pend_set;

        if (state == S_INIT_WAIT || state == S_WAIT)
          lat_cnt <= lat_last ? '0 : lat_cnt + 1'b1;
        else
          lat_cnt <= '0;

        if (state == S_RUN && rr_found) begin
          grant      <= rr_pick;
          last_grant <= rr_pick;
        end

        if (state == S_INIT_WAIT && lat_last) begin
          init_idx <= init_idx + 1'b1;
          if (init_idx == NOTE_W'(NOTES - 1)) init_done <= 1'b1;
        end

        if (cap_en) begin
          link_valid[cap_idx] <= 1'b1;
          if (mem_rdata == '1) begin
            metadata_link[cap_idx*TIME_W +: TIME_W] <= '1;
            exhausted[cap_idx] <= 1'b1;
          end else begin
            metadata_link[cap_idx*TIME_W +: TIME_W] <= mem_rdata;
            // Last addressable entry: stop rather than wrap to entry 0.
            if (ptr[cap_idx] == '1) exhausted[cap_idx] <= 1'b1;
            else                    ptr[cap_idx] <= ptr[cap_idx] + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_note_metadata_scheduler.sv
module tb_note_metadata_scheduler;

  localparam int NOTES  = 37;
  localparam int TIME_W = 16;
  localparam int IDX_W  = 8;
  localparam int RD_LAT = 2;
  localparam int NOTE_W = 6;

  logic                        clk = 1'b0;
  logic                        rst_n = 1'b0;
  logic                        start = 1'b0;
  logic [NOTES-1:0]            metadata_request = '0;
  logic [NOTES*TIME_W-1:0]     metadata_link;
  logic [NOTES-1:0]            link_valid;
  logic                        mem_rd_en;
  logic [NOTE_W+IDX_W-1:0]     mem_addr;
  logic [TIME_W-1:0]           mem_rdata = '0;
  logic                        init_done;
  logic                        busy;

  logic [NOTE_W+IDX_W-1:0]     s1_addr = '0;
  logic                        sentinel_en = 1'b0;
  int                          n_checks = 0;
  int                          n_fail = 0;
  int                          cyc = 0;
  logic [NOTE_W+IDX_W-1:0]     rd_log [$];
  int                          rd_cyc [$];

  note_metadata_scheduler #(
    .NOTES(NOTES), .TIME_W(TIME_W), .IDX_W(IDX_W), .RD_LAT(RD_LAT), .NOTE_W(NOTE_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .metadata_request(metadata_request),
    .metadata_link(metadata_link), .link_valid(link_valid),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .init_done(init_done), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory: note*64+entry, optional end sentinel on note 4 entry 1.
  function automatic logic [15:0] mem_model(input logic [13:0] a);
    logic [5:0] note;
    logic [7:0] ent;
    note = a[13:8];
    ent  = a[7:0];
    if (sentinel_en && note == 6'd4 && ent == 8'd1) return 16'hFFFF;
    return {4'b0, note, 6'b0} + {8'b0, ent};
  endfunction

  // Two register stages: data present RD_LAT cycles after the strobe cycle.
  always @(posedge clk) begin
    s1_addr   <= mem_addr;
    mem_rdata <= mem_model(s1_addr);
  end

  always @(negedge clk) begin
    if (rst_n && mem_rd_en) begin
      rd_log.push_back(mem_addr);
      rd_cyc.push_back(cyc);
    end
  end

  function automatic logic [15:0] slice_of(input int i);
    return metadata_link[i*TIME_W +: TIME_W];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_req(input int n);
    metadata_request[n] = 1'b1;
    tick();
    metadata_request[n] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      start = 1'($urandom_range(0, 1));
      metadata_request = NOTES'({$urandom(), $urandom()});
      tick();
    end
    n_checks++; if (metadata_link !== '0) begin n_fail++; $display("FAIL reset_link got %h want 0", metadata_link); end
    n_checks++; if (link_valid !== '0) begin n_fail++; $display("FAIL reset_valid got %h want 0", link_valid); end
    n_checks++; if (mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en got %b want 0", mem_rd_en); end
    n_checks++; if (mem_addr !== '0) begin n_fail++; $display("FAIL reset_addr got %h want 0", mem_addr); end
    n_checks++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL reset_init_done got %b want 0", init_done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    start = 1'b0;
    rd_log.delete();
    rd_cyc.delete();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      metadata_request = ~metadata_request;
      tick();
    end
    metadata_request = '0;
    tick();
    tick();
    n_checks++; if (rd_log.size() != 0) begin n_fail++; $display("FAIL idle_reads got %0d want 0", rd_log.size()); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %b want 0", busy); end
    n_checks++; if (link_valid !== '0) begin n_fail++; $display("FAIL idle_valid got %h want 0", link_valid); end
  endtask

  task automatic test_preload();
    int got;
    rd_log.delete();
    rd_cyc.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    got = 0;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (init_done === 1'b1) begin
        got = k;
        break;
      end
    end
    n_checks++; if (got != 111) begin n_fail++; $display("FAIL preload_time got %0d cycles want 111 (0 = timeout)", got); end
    n_checks++; if (rd_log.size() != 37) begin n_fail++; $display("FAIL preload_reads got %0d want 37", rd_log.size()); end
    for (int i = 0; i < NOTES && i < rd_log.size(); i++) begin
      n_checks++;
      if (rd_log[i] !== {6'(i), 8'd0}) begin n_fail++; $display("FAIL preload_addr[%0d] got %h want %h", i, rd_log[i], {6'(i), 8'd0}); end
    end
    for (int i = 0; i < NOTES; i++) begin
      n_checks++;
      if (slice_of(i) !== 16'(i * 64)) begin n_fail++; $display("FAIL preload_slice[%0d] got %0d want %0d", i, slice_of(i), i * 64); end
    end
    n_checks++; if (link_valid !== '1) begin n_fail++; $display("FAIL preload_valid got %h want all ones", link_valid); end
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL preload_busy got %b want 0", busy); end
  endtask

  task automatic test_single();
    rd_log.delete();
    rd_cyc.delete();
    metadata_request[2] = 1'b1;
    tick();
    metadata_request[2] = 1'b0;
    n_checks++; if (mem_rd_en !== 1'b1) begin n_fail++; $display("FAIL single_rd_en got %b want 1", mem_rd_en); end
    n_checks++; if (mem_addr !== 14'h0201) begin n_fail++; $display("FAIL single_addr got %h want 0201", mem_addr); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got %b want 1", busy); end
    tick();
    tick();
    n_checks++; if (slice_of(2) !== 16'd128) begin n_fail++; $display("FAIL single_early got %0d want 128", slice_of(2)); end
    tick();
    n_checks++; if (slice_of(2) !== 16'd129) begin n_fail++; $display("FAIL single_first got %0d want 129", slice_of(2)); end
    tick();
    pulse_req(2);
    tick();
    tick();
    tick();
    n_checks++; if (slice_of(2) !== 16'd130) begin n_fail++; $display("FAIL single_second got %0d want 130", slice_of(2)); end
    n_checks++; if (rd_log.size() != 2) begin n_fail++; $display("FAIL single_reads got %0d want 2", rd_log.size()); end
    if (rd_log.size() >= 2) begin
      n_checks++; if (rd_log[1] !== 14'h0202) begin n_fail++; $display("FAIL single_addr2 got %h want 0202", rd_log[1]); end
    end
  endtask

  task automatic test_simultaneous();
    pulse_req(3);
    for (int i = 0; i < 5; i++) tick();
    n_checks++; if (slice_of(3) !== 16'd193) begin n_fail++; $display("FAIL simul_prime got %0d want 193", slice_of(3)); end
    rd_log.delete();
    rd_cyc.delete();
    metadata_request[0]  = 1'b1;
    metadata_request[5]  = 1'b1;
    metadata_request[36] = 1'b1;
    tick();
    metadata_request = '0;
    for (int i = 0; i < 13; i++) tick();
    n_checks++; if (rd_log.size() != 3) begin n_fail++; $display("FAIL simul_reads got %0d want 3", rd_log.size()); end
    if (rd_log.size() >= 3) begin
      n_checks++; if (rd_log[0] !== 14'h0501) begin n_fail++; $display("FAIL simul_first got %h want 0501", rd_log[0]); end
      n_checks++; if (rd_log[1] !== 14'h2401) begin n_fail++; $display("FAIL simul_second got %h want 2401", rd_log[1]); end
      n_checks++; if (rd_log[2] !== 14'h0001) begin n_fail++; $display("FAIL simul_third got %h want 0001", rd_log[2]); end
      n_checks++; if (rd_cyc[1] - rd_cyc[0] != 3) begin n_fail++; $display("FAIL simul_gap1 got %0d want 3", rd_cyc[1] - rd_cyc[0]); end
      n_checks++; if (rd_cyc[2] - rd_cyc[1] != 3) begin n_fail++; $display("FAIL simul_gap2 got %0d want 3", rd_cyc[2] - rd_cyc[1]); end
    end
    n_checks++; if (slice_of(5) !== 16'd321) begin n_fail++; $display("FAIL simul_slice5 got %0d want 321", slice_of(5)); end
    n_checks++; if (slice_of(36) !== 16'd2305) begin n_fail++; $display("FAIL simul_slice36 got %0d want 2305", slice_of(36)); end
    n_checks++; if (slice_of(0) !== 16'd1) begin n_fail++; $display("FAIL simul_slice0 got %0d want 1", slice_of(0)); end
  endtask

  task automatic test_sentinel();
    sentinel_en = 1'b1;
    rd_log.delete();
    rd_cyc.delete();
    pulse_req(4);
    for (int i = 0; i < 5; i++) tick();
    n_checks++; if (slice_of(4) !== 16'hFFFF) begin n_fail++; $display("FAIL sentinel_slice got %h want FFFF", slice_of(4)); end
    n_checks++; if (link_valid[4] !== 1'b1) begin n_fail++; $display("FAIL sentinel_valid got %b want 1", link_valid[4]); end
    n_checks++; if (rd_log.size() != 1) begin n_fail++; $display("FAIL sentinel_reads got %0d want 1", rd_log.size()); end
    rd_log.delete();
    rd_cyc.delete();
    pulse_req(4);
    for (int i = 0; i < 8; i++) tick();
    n_checks++; if (rd_log.size() != 0) begin n_fail++; $display("FAIL exhausted_reads got %0d want 0", rd_log.size()); end
    n_checks++; if (slice_of(4) !== 16'hFFFF) begin n_fail++; $display("FAIL exhausted_slice got %h want FFFF", slice_of(4)); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL exhausted_busy got %b want 0", busy); end
  endtask

  task automatic test_start_mid_fetch();
    int got;
    metadata_request[2] = 1'b1;
    tick();
    metadata_request[2] = 1'b0;
    n_checks++; if (mem_addr !== 14'h0203) begin n_fail++; $display("FAIL midfetch_addr got %h want 0203", mem_addr); end
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    rd_log.delete();
    rd_cyc.delete();
    n_checks++; if (link_valid !== '0) begin n_fail++; $display("FAIL restart_valid got %h want 0", link_valid); end
    n_checks++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL restart_init_done got %b want 0", init_done); end
    tick();
    n_checks++; if (slice_of(2) !== 16'd130) begin n_fail++; $display("FAIL stale_capture got %0d want 130", slice_of(2)); end
    pulse_req(7);
    got = 0;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (init_done === 1'b1) begin
        got = k;
        break;
      end
    end
    n_checks++; if (got != 109) begin n_fail++; $display("FAIL restart_time got %0d cycles want 109 (0 = timeout)", got); end
    for (int i = 0; i < 10; i++) tick();
    n_checks++; if (rd_log.size() != 37) begin n_fail++; $display("FAIL restart_reads got %0d want 37", rd_log.size()); end
    if (rd_log.size() >= 1) begin
      n_checks++; if (rd_log[0] !== 14'h0000) begin n_fail++; $display("FAIL restart_first_addr got %h want 0000", rd_log[0]); end
    end
    n_checks++; if (slice_of(0) !== 16'd0) begin n_fail++; $display("FAIL restart_slice0 got %0d want 0", slice_of(0)); end
    n_checks++; if (slice_of(2) !== 16'd128) begin n_fail++; $display("FAIL restart_slice2 got %0d want 128", slice_of(2)); end
    n_checks++; if (slice_of(4) !== 16'd256) begin n_fail++; $display("FAIL restart_slice4 got %0d want 256", slice_of(4)); end
    n_checks++; if (slice_of(7) !== 16'd448) begin n_fail++; $display("FAIL restart_slice7 got %0d want 448", slice_of(7)); end
    n_checks++; if (link_valid !== '1) begin n_fail++; $display("FAIL restart_valid_all got %h want all ones", link_valid); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_preload();
    test_single();
    test_simultaneous();
    test_sentinel();
    test_start_mid_fetch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
